axis_frame_arbiter: RTL
=======================

# axis_frame_arbiter

Frame-aligned 2:1 AXI4-Stream arbiter that sits in the AXI clock domain in front of the AXI-Stream-to-VGA bridge. It shares the bridge input between two video sources, typically a test-pattern generator and a framebuffer DMA reader. Source changes happen only at frame boundaries, so the display never shows a torn frame. It checks frame geometry against the configured resolution and resynchronises to the next start-of-frame (TUSER) on any violation.

## Interface
- DATA_WIDTH, 16: pixel width (RGB565).
- H_ACTIVE, 640: pixels per line (beats per TLAST).
- V_ACTIVE, 480: lines per frame.
- axi_clk_i  in  1  AXI stream clock; the only clock.
- axi_rst_i  in  1  reset, asynchronous, active-high.
- sel_i  in  1  requested source (0 = s0, 1 = s1); level, sampled only at frame boundaries.
- s0_tdata_i / s1_tdata_i  in  DATA_WIDTH  source pixel data.
- s0_tuser_i / s1_tuser_i  in  1  start of frame (first pixel of line 0).
- s0_tlast_i / s1_tlast_i  in  1  end of line.
- s0_tvalid_i / s1_tvalid_i  in  1  source valid.
- s0_tready_o / s1_tready_o  out  1  source ready.
- m_tdata_o, m_tuser_o, m_tlast_o, m_tvalid_o  out  DATA_WIDTH,1,1,1  stream to the VGA bridge.
- m_tready_i  in  1  bridge ready (= !FIFO full).
- grant_o  out  1  source currently owning the output.
- frame_done_o  out  1  one-cycle pulse on the final TLAST handshake of a complete frame.
- sync_err_o  out  1  one-cycle pulse on each geometry violation.
- err_cnt_o  out  8  violation count, saturates at 255.

## Operation
- States: IDLE, SYNC, PASS.
- IDLE: entered at reset and lasts exactly one cycle. It latches grant_o <= sel_i and moves to SYNC.
- SYNC (hunting for start of frame on the granted source):
  - Granted tready = !tuser, so non-SOF beats are consumed and discarded.
  - m_tvalid_o = 0.
  - On a granted beat with tvalid&&tuser: clear the pixel and line counters, go to PASS. That beat is not consumed in SYNC.
- PASS:
  - Combinational passthrough: m_* = granted s_*, granted tready = m_tready_i.
  - Counters: pix_cnt ($clog2(H_ACTIVE) bits) increments on each handshake. line_cnt ($clog2(V_ACTIVE) bits) increments on each TLAST handshake. pix_cnt clears on TLAST.
  - Position (0,0) with valid && !tuser: the beat is not forwarded (m_tvalid_o=0, tready=0). Pulse sync_err_o and go to SYNC.
  - TUSER handshake at a position other than (0,0): forward it, pulse sync_err_o, and treat it as a new frame. After this beat, pix_cnt=1 and line_cnt=0.
  - TLAST handshake with pix_cnt != H_ACTIVE-1, or pix_cnt reaching H_ACTIVE-1 without TLAST: forward the beat, pulse sync_err_o, go to SYNC.
  - TLAST handshake with pix_cnt == H_ACTIVE-1 and line_cnt == V_ACTIVE-1:
    - Pulse frame_done_o and clear the counters.
    - If sel_i != grant_o: toggle grant_o and go to SYNC. Otherwise stay in PASS.
- The non-granted source always sees tready=0 and is never consumed.
- err_cnt_o increments on every sync_err_o pulse and saturates at 255.

## Timing
- Reset values: state IDLE, grant_o=0, counters 0, frame_done_o=0, sync_err_o=0, err_cnt_o=0. Because state is IDLE, m_tvalid_o=0 and both s*_tready_o=0.
- Data latency in PASS is 0 cycles, with no registers in the data path. Ready propagates combinationally.
- After reset, the earliest forwarded beat is at cycle 2 (IDLE at cycle 0, SYNC evaluates at cycle 1, PASS at cycle 2).
- On a source switch, the first beat of the new source follows the final TLAST handshake by at least 1 cycle (the SYNC cycle).
- frame_done_o, sync_err_o and grant_o are registered and assert in the cycle after the triggering handshake.
- sel_i toggling mid-frame has no effect until that frame's final TLAST. Multiple toggles within a frame: only the level present at that handshake counts.
- Stalls: m_tready_i=0 holds all counters. Outputs remain stable while m_tvalid_o=1, per AXI-Stream rules.
- Asynchronous reset mid-frame: outputs return to their reset values immediately. The partial frame is abandoned, and the bridge resynchronises via TUSER.

## Test plan
- Reset, sel_i=0, s0 streams 2 clean 640x480 frames with m_tready_i=1 -> 614400 beats forwarded unchanged, frame_done_o pulses twice, err_cnt_o=0.
- sel_i toggles 0->1 at line 200 of frame 1, s1 streaming continuously -> frame 1 completes from s0, grant_o=1 one cycle after the final TLAST, and the next forwarded beat is s1's TUSER beat.
- s0 starts mid-frame (first beat at pixel 37 of line 5) -> beats dropped until TUSER, no forwarding before it, err_cnt_o=0.
- Line 10 carries TLAST at pixel 600 -> sync_err_o one pulse, err_cnt_o=1, output silent until the next TUSER, then a clean frame passes.
- Random m_tready_i backpressure (50%) plus random tvalid gaps -> output stream identical to the input frame, no dropped or duplicated beats, s1_tready_o stays 0.
- Assert axi_rst_i at line 300 -> m_tvalid_o=0 in the same cycle, err_cnt_o=0. After release, forwarding resumes only at the next TUSER.

Source files
------------

// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter: frame-aligned 2:1 AXI4-Stream arbiter with geometry check and resync on TUSER
module axis_frame_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic                  axi_clk_i,
  input  logic                  axi_rst_i,
  input  logic                  sel_i,
  input  logic [DATA_WIDTH-1:0] s0_tdata_i,
  input  logic                  s0_tuser_i,
  input  logic                  s0_tlast_i,
  input  logic                  s0_tvalid_i,
  output logic                  s0_tready_o,
  input  logic [DATA_WIDTH-1:0] s1_tdata_i,
  input  logic                  s1_tuser_i,
  input  logic                  s1_tlast_i,
  input  logic                  s1_tvalid_i,
  output logic                  s1_tready_o,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tuser_o,
  output logic                  m_tlast_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic                  grant_o,
  output logic                  frame_done_o,
  output logic                  sync_err_o,
  output logic [7:0]            err_cnt_o
);
  localparam int PW = H_ACTIVE > 1 ? $clog2(H_ACTIVE) : 1;
  localparam int LW = V_ACTIVE > 1 ? $clog2(V_ACTIVE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(H_ACTIVE - 1);
  localparam logic [LW-1:0] L_LAST = LW'(V_ACTIVE - 1);
  typedef enum logic [1:0] {IDLE, SYNC, PASS} state_t;
  state_t state;
  logic [PW-1:0] pix_cnt, pix_e;
  logic [LW-1:0] line_cnt, line_e;
  logic g_valid, g_user, g_last, g_ready, at_sof, blk, hs, bad_last, frame_end, err;
  // a TUSER beat always counts as position (0,0), wherever the counters were
  always_comb begin
    g_valid = grant_o ? s1_tvalid_i : s0_tvalid_i;
    g_user = grant_o ? s1_tuser_i : s0_tuser_i;
    g_last = grant_o ? s1_tlast_i : s0_tlast_i;
    at_sof = pix_cnt == '0 && line_cnt == '0;
    blk = state == PASS && at_sof && g_valid && !g_user;
    g_ready = state == SYNC ? !g_user : state == PASS && !blk && m_tready_i;
    m_tvalid_o = state == PASS && g_valid && !blk;
    hs = m_tvalid_o && m_tready_i;
    pix_e = g_user ? '0 : pix_cnt;
    line_e = g_user ? '0 : line_cnt;
    bad_last = g_last != (pix_e == P_LAST);
    frame_end = g_last && pix_e == P_LAST && line_e == L_LAST;
    err = blk || hs && (bad_last || g_user && !at_sof);
  end
  assign m_tdata_o = grant_o ? s1_tdata_i : s0_tdata_i;
  assign m_tuser_o = g_user;
  assign m_tlast_o = g_last;
  assign s0_tready_o = !grant_o && g_ready;
  assign s1_tready_o = grant_o && g_ready;
  always_ff @(posedge axi_clk_i or posedge axi_rst_i) begin
    if (axi_rst_i) begin
      state <= IDLE;
      grant_o <= 1'b0;
      pix_cnt <= '0;
      line_cnt <= '0;
      frame_done_o <= 1'b0;
      sync_err_o <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      frame_done_o <= 1'b0;
      sync_err_o <= err;
      if (err && err_cnt_o != 8'hff) err_cnt_o <= err_cnt_o + 8'd1;
      case (state)
        IDLE: begin
          grant_o <= sel_i;
          state <= SYNC;
        end
        SYNC: if (g_valid && g_user) begin
          pix_cnt <= '0;
          line_cnt <= '0;
          state <= PASS;
        end
        PASS: if (blk || hs && bad_last) state <= SYNC;
        else if (hs && frame_end) begin
          pix_cnt <= '0;
          line_cnt <= '0;
          frame_done_o <= 1'b1;
          if (sel_i != grant_o) begin
            grant_o <= !grant_o;
            state <= SYNC;
          end
        end else if (hs) begin
          pix_cnt <= g_last ? '0 : pix_e + 1'b1;
          line_cnt <= g_last ? line_e + 1'b1 : line_e;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
